wb_commit_stage: RTL
====================

# wb_commit_stage

Parametrised writeback/commit stage for the five-stage pipeline, successor to the fixed 32-bit writeback stage. It accepts one instruction per cycle from the memory stage and drives the register-file write port and hazard-detection status. It also commits exceptions and `ertn` by raising a one-cycle pipeline flush with a redirect target, and can optionally buffer the commit trace in a FIFO so that a slow trace consumer back-pressures the pipeline instead of losing entries.

## Interface
Parameters:
- `XLEN`, 32, datapath and PC width
- `RF_AW`, 5, register-file address width
- `ECODE_W`, 6, exception code width
- `TRACE_DEPTH`, 4, trace FIFO entries; power of two, ≥2; used only with `WB_TRACE_FIFO_EN`

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `ms2ws_valid` in 1: memory stage holds a valid instruction
- `ws_allowin` out 1: stage accepts an instruction this cycle
- `ms_pc` in XLEN: instruction PC
- `ms_gr_we` in 1: instruction writes the register file
- `ms_dest` in RF_AW: destination register
- `ms_result` in XLEN: write data
- `ms_exc` in 1: instruction carries an exception
- `ms_ecode` in ECODE_W: exception code
- `ms_ertn` in 1: instruction is `ertn`
- `csr_eentry` in XLEN: exception entry address
- `csr_era` in XLEN: exception return address
- `rf_we` out 1: register-file write enable
- `rf_waddr` out RF_AW: write address
- `rf_wdata` out XLEN: write data
- `ws_valid` out 1: stage occupied
- `ws_gr_we` out 1: registered `ms_gr_we`, for hazard detection
- `ws_dest` out RF_AW: registered `ms_dest`, for hazard detection
- `wb_flush` out 1: flush all younger stages
- `wb_flush_target` out XLEN: fetch redirect target
- `exc_commit` out 1: exception committed (CSR update strobe)
- `exc_pc` out XLEN: PC of the excepting instruction (written to ERA)
- `exc_ecode` out ECODE_W: committed exception code
- `ertn_commit` out 1: `ertn` committed
- `trace_valid` out 1: trace entry available
- `trace_ready` in 1: consumer takes the entry
- `trace_pc` out XLEN: trace PC
- `trace_we` out 4: trace write-byte enables
- `trace_wnum` out RF_AW: trace destination register
- `trace_wdata` out XLEN: trace write data

## Operation
- Single stage register: `ws_pc`, `ws_gr_we`, `ws_dest`, `ws_result`, `ws_exc`, `ws_ecode`, `ws_ertn`, and `ws_valid`.
- `ws_allowin = ~ws_valid | ws_ready_go`.
- Load: on `ms2ws_valid & ws_allowin`, all fields are captured.
- `ws_valid` next value:
  - 0 on reset;
  - 0 if `commit & flush`;
  - otherwise `ms2ws_valid` when `ws_allowin`.
- `commit = ws_valid & ws_ready_go`.
- `flush = ws_exc | ws_ertn`.
- `need_trace = ws_gr_we & ~flush`.
- Register-file write: `rf_we = commit & need_trace`; `rf_waddr = ws_dest`; `rf_wdata = ws_result`.
- Exception commit (`ws_exc` set):
  - `wb_flush = 1`, `wb_flush_target = csr_eentry`;
  - `exc_commit = 1`, `exc_pc = ws_pc`, `exc_ecode = ws_ecode`;
  - no register-file write.
- `ertn` commit: `wb_flush = 1`, `wb_flush_target = csr_era`, `ertn_commit = 1`.
- Exception and `ertn` both set: the exception wins; `ertn_commit = 0`.
- An instruction loaded in the same cycle as a flush commit is discarded (`ws_valid` goes to 0).
- Flush and commit strobes are combinational from stage state and last exactly one cycle.
- `trace_we = {4{1'b1}}` whenever `trace_valid` is high.

## Timing
- Reset values: `ws_valid`, `ws_gr_we`, `ws_dest`, and all stage registers are 0. All outputs are 0 except `ws_allowin`, which is 1. The trace FIFO is empty.
- An instruction accepted at edge N commits in cycle N+1 when `ws_ready_go` is high. `rf_we` and the flush/exception strobes are visible in that same cycle.
- Throughput: one instruction per cycle with no back-pressure.
- `ws_ready_go = 1` except under `WB_TRACE_FIFO_EN` when `need_trace & fifo_full`.
- While stalled, stage contents are held and `ws_allowin = 0`. Stalls apply only to instructions that push a trace entry.
- Reset during a stall: the stage empties and no commit happens.

## Configuration
- `WB_TRACE_FIFO_EN` defined:
  - `TRACE_DEPTH`-entry FIFO with pointers `$clog2(TRACE_DEPTH)+1` bits wide, wrapping modulo 2·DEPTH; full when the pointers differ only in the MSB.
  - Push on `rf_we`. Pop on `trace_valid & trace_ready`.
  - Push is refused when full, even if a pop occurs in the same cycle. Push and pop together when neither full nor empty leaves the count unchanged.
  - `trace_valid = ~empty`. The trace outputs show the head entry and are 0 when empty.
  - An entry appears on `trace_valid` one cycle after its commit.
- Not defined:
  - `trace_valid = rf_we`; `trace_pc/wnum/wdata = ws_pc/ws_dest/ws_result`, same cycle as the write.
  - `trace_ready` is ignored and the stage never stalls.

## Test plan
- Back-to-back stream of 3 instructions (dest 1/2/3, data 0x11/0x22/0x33), `trace_ready = 1`: `rf_we` high 3 consecutive cycles with matching addr/data, no stall.
- `ms_exc = 1`, `ecode = 0x0B`, pc 0x1c00_0100, `csr_eentry = 0x1c00_8000`, `gr_we = 1`: one-cycle `wb_flush`/`exc_commit`, target 0x1c00_8000, `exc_pc = 0x1c00_0100`, `rf_we = 0`. A younger instruction presented in the same cycle is dropped.
- `ertn` with `csr_era = 0x1c00_0104`: one-cycle `wb_flush`, `ertn_commit = 1`, target 0x1c00_0104. `exc` and `ertn` together → exception path only.
- `WB_TRACE_FIFO_EN`, DEPTH 4, `trace_ready = 0`, 6 writing instructions: 4 commit, fifth stalls with `ws_allowin = 0`. Raising `trace_ready` drains the entries in order and the remaining instructions commit.
- `WB_TRACE_FIFO_EN`, `trace_ready` toggled every cycle over 10 writes: pointer wrap-around produces no lost or duplicated entries. A non-writing instruction commits even while the FIFO is full.
- Reset asserted mid-stall: next cycle `ws_valid = 0`, `trace_valid = 0`, `rf_we = 0`.

Source files
------------

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: register-file write, exception/ertn flush, commit trace.
// Define WB_TRACE_FIFO_EN to buffer the trace in a FIFO that back-pressures the pipeline.
module wb_commit_stage #(
  parameter int XLEN        = 32,
  parameter int RF_AW       = 5,
  parameter int ECODE_W     = 6,
  parameter int TRACE_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ms2ws_valid,
  output logic               ws_allowin,
  input  logic [XLEN-1:0]    ms_pc,
  input  logic               ms_gr_we,
  input  logic [RF_AW-1:0]   ms_dest,
  input  logic [XLEN-1:0]    ms_result,
  input  logic               ms_exc,
  input  logic [ECODE_W-1:0] ms_ecode,
  input  logic               ms_ertn,
  input  logic [XLEN-1:0]    csr_eentry,
  input  logic [XLEN-1:0]    csr_era,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               ws_valid,
  output logic               ws_gr_we,
  output logic [RF_AW-1:0]   ws_dest,
  output logic               wb_flush,
  output logic [XLEN-1:0]    wb_flush_target,
  output logic               exc_commit,
  output logic [XLEN-1:0]    exc_pc,
  output logic [ECODE_W-1:0] exc_ecode,
  output logic               ertn_commit,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [XLEN-1:0]    trace_pc,
  output logic [3:0]         trace_we,
  output logic [RF_AW-1:0]   trace_wnum,
  output logic [XLEN-1:0]    trace_wdata
);

  logic [XLEN-1:0]    ws_pc;
  logic [XLEN-1:0]    ws_result;
  logic               ws_exc;
  logic [ECODE_W-1:0] ws_ecode;
  logic               ws_ertn;

  logic ws_ready_go;
  logic commit;
  logic flush;
  logic need_trace;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid  <= 1'b0;
      ws_pc     <= '0;
      ws_gr_we  <= 1'b0;
      ws_dest   <= '0;
      ws_result <= '0;
      ws_exc    <= 1'b0;
      ws_ecode  <= '0;
      ws_ertn   <= 1'b0;
    end else begin
      // A flushing commit also discards whatever the memory stage hands over this cycle.
      if (commit && flush) begin
        ws_valid <= 1'b0;
      end else if (ws_allowin) begin
        ws_valid <= ms2ws_valid;
      end
      if (ms2ws_valid && ws_allowin) begin
        ws_pc     <= ms_pc;
        ws_gr_we  <= ms_gr_we;
        ws_dest   <= ms_dest;
        ws_result <= ms_result;
        ws_exc    <= ms_exc;
        ws_ecode  <= ms_ecode;
        ws_ertn   <= ms_ertn;
      end
    end
  end

  assign flush      = ws_exc | ws_ertn;
  assign need_trace = ws_gr_we & ~flush;
  assign commit     = ws_valid & ws_ready_go;
  assign ws_allowin = ~ws_valid | ws_ready_go;

  assign rf_we    = commit & need_trace;
  assign rf_waddr = ws_dest;
  assign rf_wdata = ws_result;

  assign wb_flush    = commit & flush;
  assign exc_commit  = commit & ws_exc;
  assign ertn_commit = commit & ws_ertn & ~ws_exc;
  assign exc_pc      = ws_pc;
  assign exc_ecode   = ws_ecode;

  always_comb begin
    wb_flush_target = '0;
    if (exc_commit) begin
      wb_flush_target = csr_eentry;
    end else if (ertn_commit) begin
      wb_flush_target = csr_era;
    end
  end

  assign trace_we = {4{trace_valid}};

`ifdef WB_TRACE_FIFO_EN
  localparam int PTR_W = $clog2(TRACE_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic [XLEN-1:0]  pc_mem   [TRACE_DEPTH];
  logic [RF_AW-1:0] dest_mem [TRACE_DEPTH];
  logic [XLEN-1:0]  data_mem [TRACE_DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {IDX_W{1'b0}}});
  assign push       = rf_we & ~fifo_full;
  assign pop        = trace_valid & trace_ready;

  assign ws_ready_go = ~(need_trace & fifo_full);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[IDX_W-1:0]]   <= ws_pc;
      dest_mem[wr_ptr[IDX_W-1:0]] <= ws_dest;
      data_mem[wr_ptr[IDX_W-1:0]] <= ws_result;
    end
  end

  assign trace_valid = ~fifo_empty;
  assign trace_pc    = fifo_empty ? '0 : pc_mem[rd_ptr[IDX_W-1:0]];
  assign trace_wnum  = fifo_empty ? '0 : dest_mem[rd_ptr[IDX_W-1:0]];
  assign trace_wdata = fifo_empty ? '0 : data_mem[rd_ptr[IDX_W-1:0]];
`else
  localparam int unused_trace_depth = TRACE_DEPTH;
  logic unused_trace_ready;

  // Without the FIFO the trace mirrors the register-file write and never stalls.
  assign unused_trace_ready = trace_ready;
  assign ws_ready_go        = 1'b1;
  assign trace_valid        = rf_we;
  assign trace_pc           = ws_pc;
  assign trace_wnum         = ws_dest;
  assign trace_wdata        = ws_result;
`endif

endmodule
